// File: rtl/imem_program_loader_if.sv
// ---------------------------------------------------------------------------
// imem_program_loader_if
//   Bundles the two buses the program loader sits between:
//     - the incoming instruction stream (valid/ready handshake + last marker)
//     - the instruction-memory write port of the multicycle CPU
//
//   Signals:
//     in_valid  stream word valid
//     in_data   stream instruction word            [DATA_W]
//     in_last   final word of the program
//     in_ready  loader can accept a word
//     wr_en     instruction-memory write enable
//     wr_addr   instruction-memory write address   [ADDR_W]
//     wr_data   instruction-memory write data      [DATA_W]
//
//   Modports:
//     master  environment side: drives the stream, observes ready and writes
//     slave   loader side: consumes the stream, drives ready and the writes
// ---------------------------------------------------------------------------
interface imem_program_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_program_loader.sv
// ---------------------------------------------------------------------------
// imem_program_loader
//   Program-load sequencer between an external instruction stream and the
//   multicycle CPU's instruction-memory write port. Words accepted on the
//   stream are written to consecutive addresses starting at a programmable
//   base. When the word carrying in_last has been written the CPU start level
//   is raised and held until halt or a new load.
//
//   Parameters:
//     DATA_W  instruction word width
//     ADDR_W  instruction-memory address width
//     DEPTH   instruction-memory capacity in words (must be <= 2**ADDR_W)
//
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous, active-low reset
//     load_req      one-cycle pulse: start loading a new program
//     base_addr     first write address, sampled with an accepted load_req
//     halt          stop the CPU (RUN) or abort a load (LOAD); back to IDLE
//     bus           stream + write port (slave side of the interface)
//     cpu_start     CPU start level
//     busy          high in LOAD or FLUSH
//     done          one-cycle pulse on entry to RUN
//     overflow_err  sticky: image exceeded DEPTH words
//     word_count    words written in the current/last load
//
//   All outputs are registered. States: IDLE, LOAD, FLUSH, RUN, ERR.
// ---------------------------------------------------------------------------
module imem_program_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                halt,
    imem_program_loader_if.slave bus,
    output logic                cpu_start,
    output logic                busy,
    output logic                done,
    output logic                overflow_err,
    output logic [ADDR_W:0]     word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr;        // next write address, wraps modulo 2**ADDR_W
    logic              accept;
    logic              start_load;

    assign accept = bus.in_valid & bus.in_ready;

    // A load request starts (or restarts) a load from every state except
    // FLUSH. In LOAD and RUN a simultaneous halt takes priority.
    always_comb begin
        start_load = 1'b0;
        unique case (state)
            S_IDLE, S_ERR: start_load = load_req;
            S_LOAD, S_RUN: start_load = load_req & ~halt;
            default:       start_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_start    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            word_count   <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            done      <= 1'b0;

            if (start_load) begin
                // A write registered on the previous edge is already on the
                // port this cycle, so a restart never cuts it short. A word
                // offered in the same cycle as the restart is discarded.
                state        <= S_LOAD;
                ptr          <= base_addr;
                word_count   <= '0;
                overflow_err <= 1'b0;
                bus.in_ready <= 1'b1;
                busy         <= 1'b1;
                cpu_start    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        // halt is ignored here; wait for load_req
                    end

                    S_LOAD: begin
                        if (halt) begin
                            state        <= S_IDLE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                        end else if (accept) begin
                            // word_count counts on the accept edge, so it is
                            // current for the next accept even back-to-back.
                            if (word_count == DEPTH_CNT) begin
                                // Overflow beats in_last; the word is dropped.
                                state        <= S_ERR;
                                overflow_err <= 1'b1;
                                bus.in_ready <= 1'b0;
                                busy         <= 1'b0;
                            end else begin
                                bus.wr_en   <= 1'b1;
                                bus.wr_addr <= ptr;
                                bus.wr_data <= bus.in_data;
                                ptr         <= ptr + 1'b1;
                                word_count  <= word_count + 1'b1;
                                if (bus.in_last) begin
                                    state        <= S_FLUSH;
                                    bus.in_ready <= 1'b0;
                                end
                            end
                        end
                    end

                    S_FLUSH: begin
                        // The final write is on the port during this cycle.
                        state     <= S_RUN;
                        busy      <= 1'b0;
                        cpu_start <= 1'b1;
                        done      <= 1'b1;
                    end

                    S_RUN: begin
                        if (halt) begin
                            state     <= S_IDLE;
                            cpu_start <= 1'b0;
                        end
                    end

                    S_ERR: begin
                        // Only load_req or reset leave ERR; halt is ignored.
                    end

                    default: begin
                        state        <= S_IDLE;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        cpu_start    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    logic clk;
    logic rst;

    // Shared stimulus, steered to one of two DUTs by sel
    // (sel=0: DEPTH=64 instance, sel=1: DEPTH=8 instance).
    logic              sel;
    logic              lreq;
    logic              hlt;
    logic [ADDR_W-1:0] base;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    imem_program_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus64 ();
    imem_program_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus8 ();

    logic            start64, busy64, done64, ovf64;
    logic            start8,  busy8,  done8,  ovf8;
    logic [ADDR_W:0] cnt64, cnt8;

    assign bus64.in_valid = s_valid & ~sel;
    assign bus64.in_data  = s_data;
    assign bus64.in_last  = s_last;
    assign bus8.in_valid  = s_valid & sel;
    assign bus8.in_data   = s_data;
    assign bus8.in_last   = s_last;

    imem_program_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(64)) u_dut64 (
        .clk          (clk),
        .rst          (rst),
        .load_req     (lreq & ~sel),
        .base_addr    (base),
        .halt         (hlt & ~sel),
        .bus          (bus64),
        .cpu_start    (start64),
        .busy         (busy64),
        .done         (done64),
        .overflow_err (ovf64),
        .word_count   (cnt64)
    );

    imem_program_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .load_req     (lreq & sel),
        .base_addr    (base),
        .halt         (hlt & sel),
        .bus          (bus8),
        .cpu_start    (start8),
        .busy         (busy8),
        .done         (done8),
        .overflow_err (ovf8),
        .word_count   (cnt8)
    );

    // Observed outputs of the selected DUT
    logic              o_rdy, o_wr_en, o_start, o_busy, o_done, o_ovf;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic [ADDR_W:0]   o_cnt;

    assign o_rdy     = sel ? bus8.in_ready : bus64.in_ready;
    assign o_wr_en   = sel ? bus8.wr_en    : bus64.wr_en;
    assign o_wr_addr = sel ? bus8.wr_addr  : bus64.wr_addr;
    assign o_wr_data = sel ? bus8.wr_data  : bus64.wr_data;
    assign o_start   = sel ? start8 : start64;
    assign o_busy    = sel ? busy8  : busy64;
    assign o_done    = sel ? done8  : done64;
    assign o_ovf     = sel ? ovf8   : ovf64;
    assign o_cnt     = sel ? cnt8   : cnt64;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log and done-pulse counter, sampled on the falling edge
    logic [ADDR_W-1:0] log_addr[$];
    logic [DATA_W-1:0] log_data[$];
    int                done_cnt = 0;

    always @(negedge clk) begin
        if (rst && o_wr_en) begin
            log_addr.push_back(o_wr_addr);
            log_data.push_back(o_wr_data);
        end
        if (rst && o_done) done_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until the loader takes it.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!o_rdy && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check_eq("rdy_timeout", 64'(o_rdy), 64'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_load(input logic [ADDR_W-1:0] b);
        base = b;
        lreq = 1'b1;
        tick();
        lreq = 1'b0;
    endtask

    // Check log entries [mark, mark+n) against prog[0..n-1] at a0+i
    logic [DATA_W-1:0] prog [20];

    task automatic check_log(input string tag, input int mark, input int n,
                             input logic [ADDR_W-1:0] a0, input logic use_prog);
        check_eq({tag, "_nwrites"}, 64'(log_addr.size() - mark), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (mark + i < log_addr.size()) begin
                check_eq({tag, "_addr"}, 64'(log_addr[mark+i]), 64'(a0 + ADDR_W'(i)));
                check_eq({tag, "_data"}, 64'(log_data[mark+i]),
                         use_prog ? 64'(prog[i % 20]) : 64'(32'hA500_0000 + i));
            end
        end
    endtask

    initial begin
        int mark;
        int dmark;

        prog[0]  = 32'h0000_0000;  // NOOP
        prog[1]  = 32'h0050_0093;  // addi r1,r0,5
        prog[2]  = 32'h0030_0113;
        prog[3]  = 32'h0020_81B3;
        prog[4]  = 32'h4020_8233;
        prog[5]  = 32'h0011_72B3;
        prog[6]  = 32'h0011_6333;
        prog[7]  = 32'h0011_43B3;
        prog[8]  = 32'h0020_9433;
        prog[9]  = 32'h0020_D4B3;
        prog[10] = 32'h0000_2503;
        prog[11] = 32'h00A0_2223;
        prog[12] = 32'h0041_0593;
        prog[13] = 32'hFFF5_8593;
        prog[14] = 32'h0000_0663;
        prog[15] = 32'h0080_06EF;
        prog[16] = 32'h0000_0713;
        prog[17] = 32'h0FF0_0713;
        prog[18] = 32'hDEAD_BEEF;
        prog[19] = 32'h0010_0793;  // LI r15,1

        sel = 1'b0; lreq = 1'b0; hlt = 1'b0; base = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        rst = 1'b0;

        // ---- reset state
        tick(); tick();
        check_eq("rst_rdy",   64'(o_rdy),     64'd0);
        check_eq("rst_wr_en", 64'(o_wr_en),   64'd0);
        check_eq("rst_start", 64'(o_start),   64'd0);
        check_eq("rst_busy",  64'(o_busy),    64'd0);
        check_eq("rst_cnt",   64'(o_cnt),     64'd0);
        rst = 1'b1;
        tick();

        // ---- basic load: 20 back-to-back words at base 0
        mark  = log_addr.size();
        dmark = done_cnt;
        pulse_load(16'h0000);
        check_eq("ld_rdy",   64'(o_rdy),   64'd1);
        check_eq("ld_busy",  64'(o_busy),  64'd1);
        check_eq("ld_wr_en", 64'(o_wr_en), 64'd0);
        for (int i = 0; i < 20; i++) begin
            send_word(prog[i], i == 19);
            if (i == 0) begin
                check_eq("lat_wr_en", 64'(o_wr_en),   64'd1);
                check_eq("lat_addr",  64'(o_wr_addr), 64'd0);
                check_eq("lat_cnt",   64'(o_cnt),     64'd1);
            end
        end
        // now in FLUSH with the 20th write on the port
        check_eq("flush_rdy",   64'(o_rdy),   64'd0);
        check_eq("flush_busy",  64'(o_busy),  64'd1);
        check_eq("flush_wr_en", 64'(o_wr_en), 64'd1);
        check_eq("flush_start", 64'(o_start), 64'd0);
        tick();
        check_eq("run_done",  64'(o_done),  64'd1);
        check_eq("run_start", 64'(o_start), 64'd1);
        check_eq("run_busy",  64'(o_busy),  64'd0);
        check_eq("run_cnt",   64'(o_cnt),   64'd20);
        tick();
        check_eq("run_done_drop", 64'(o_done), 64'd0);
        check_eq("run_start_hold", 64'(o_start), 64'd1);
        check_eq("basic_done_pulses", 64'(done_cnt - dmark), 64'd1);
        check_log("basic", mark, 20, 16'h0000, 1'b1);

        // ---- halt and load_req together in RUN: halt wins
        hlt = 1'b1; lreq = 1'b1;
        tick();
        hlt = 1'b0; lreq = 1'b0;
        check_eq("hl_start", 64'(o_start), 64'd0);
        check_eq("hl_busy",  64'(o_busy),  64'd0);
        check_eq("hl_rdy",   64'(o_rdy),   64'd0);
        tick();
        check_eq("hl_idle_busy", 64'(o_busy), 64'd0);
        pulse_load(16'h0040);
        check_eq("reload_busy", 64'(o_busy), 64'd1);
        check_eq("reload_cnt",  64'(o_cnt),  64'd0);
        check_eq("reload_rdy",  64'(o_rdy),  64'd1);
        // halt inside LOAD aborts to IDLE without starting
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        check_eq("abort_rdy",   64'(o_rdy),   64'd0);
        check_eq("abort_busy",  64'(o_busy),  64'd0);
        check_eq("abort_start", 64'(o_start), 64'd0);

        // ---- bubbled stream at base 0x0100
        mark = log_addr.size();
        pulse_load(16'h0100);
        for (int i = 0; i < 20; i++) begin
            send_word(prog[i], i == 19);
            if (i != 19) tick();   // in_valid low for one cycle
        end
        tick();
        check_eq("bub_start", 64'(o_start), 64'd1);
        check_eq("bub_cnt",   64'(o_cnt),   64'd20);
        check_eq("bub_ovf",   64'(o_ovf),   64'd0);
        check_log("bubble", mark, 20, 16'h0100, 1'b1);

        // ---- overflow on the DEPTH=8 instance
        sel = 1'b1;
        tick();
        mark = log_addr.size();
        pulse_load(16'h0000);
        for (int i = 0; i < 9; i++) send_word(32'hA500_0000 + i, 1'b0);
        check_eq("ovf_flag",  64'(o_ovf),   64'd1);
        check_eq("ovf_start", 64'(o_start), 64'd0);
        check_eq("ovf_rdy",   64'(o_rdy),   64'd0);
        check_eq("ovf_busy",  64'(o_busy),  64'd0);
        check_eq("ovf_cnt",   64'(o_cnt),   64'd8);
        check_eq("ovf_wr_en", 64'(o_wr_en), 64'd0);
        tick();
        check_log("ovf", mark, 8, 16'h0000, 1'b0);
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        check_eq("err_halt_ignored", 64'(o_ovf), 64'd1);
        check_eq("err_halt_rdy",     64'(o_rdy), 64'd0);
        pulse_load(16'h0000);
        check_eq("err_reload_ovf",  64'(o_ovf),  64'd0);
        check_eq("err_reload_busy", 64'(o_busy), 64'd1);
        check_eq("err_reload_cnt",  64'(o_cnt),  64'd0);

        // ---- exact fill: 8 words, in_last on the 8th
        mark = log_addr.size();
        for (int i = 0; i < 8; i++) send_word(32'hA500_0000 + i, i == 7);
        tick();
        check_eq("fill_done",  64'(o_done),  64'd1);
        check_eq("fill_start", 64'(o_start), 64'd1);
        check_eq("fill_ovf",   64'(o_ovf),   64'd0);
        check_eq("fill_cnt",   64'(o_cnt),   64'd8);
        check_log("fill", mark, 8, 16'h0000, 1'b0);

        // ---- async reset mid-load after 5 words (DEPTH=64 instance in RUN)
        sel = 1'b0;
        tick();
        pulse_load(16'h0020);
        check_eq("run_reload_start", 64'(o_start), 64'd0);
        for (int i = 0; i < 5; i++) send_word(prog[i], 1'b0);
        check_eq("pre_rst_cnt", 64'(o_cnt), 64'd5);
        #3;
        rst = 1'b0;
        #1;
        check_eq("arst_rdy",   64'(o_rdy),     64'd0);
        check_eq("arst_wr_en", 64'(o_wr_en),   64'd0);
        check_eq("arst_addr",  64'(o_wr_addr), 64'd0);
        check_eq("arst_data",  64'(o_wr_data), 64'd0);
        check_eq("arst_start", 64'(o_start),   64'd0);
        check_eq("arst_busy",  64'(o_busy),    64'd0);
        check_eq("arst_done",  64'(o_done),    64'd0);
        check_eq("arst_ovf",   64'(o_ovf),     64'd0);
        check_eq("arst_cnt",   64'(o_cnt),     64'd0);
        #2;
        rst = 1'b1;
        tick();
        check_eq("post_rst_rdy",  64'(o_rdy),  64'd0);
        check_eq("post_rst_busy", 64'(o_busy), 64'd0);
        pulse_load(16'h0000);
        check_eq("post_rst_load", 64'(o_rdy), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
